// File: rtl/multiway_traffic_ctrl.sv
// N-road intersection controller. Latches per-road car requests and grants the
// right of way round-robin through GREEN -> YELLOW -> ALLRED phases, timed by a
// single saturating phase counter. All outputs are registered; the phase and
// active road outputs are the FSM state itself, so checkers can bind to them.
module multiway_traffic_ctrl #(
  parameter int N_ROADS   = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int HOME      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_ROADS-1:0]           car,
  output logic [3*N_ROADS-1:0]         light,
  output logic [$clog2(N_ROADS)-1:0]   active_road,
  output logic [1:0]                   phase
);

  localparam int AW = $clog2(N_ROADS);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);
  localparam logic [AW-1:0]    HOME_IDX  = AW'(HOME);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  // Reset lamp pattern: home road green, every other road red.
  function automatic logic [3*N_ROADS-1:0] reset_pattern();
    logic [3*N_ROADS-1:0] p;
    for (int i = 0; i < N_ROADS; i++) begin
      p[3*i +: 3] = (i == HOME) ? 3'b100 : 3'b001;
    end
    return p;
  endfunction

  localparam logic [3*N_ROADS-1:0] RESET_LIGHT = reset_pattern();

  // (a + k) mod N_ROADS for 0 <= k < N_ROADS.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= N_ROADS) s = s - N_ROADS;
    return AW'(s);
  endfunction

  phase_e               phase_q, phase_d;
  logic [AW-1:0]        active_q, active_d;
  logic [AW-1:0]        next_q, next_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_ROADS-1:0]   req_q, req_d;
  logic [3*N_ROADS-1:0] light_q, light_d;

  logic [N_ROADS-1:0]   act_onehot;
  logic                 others;
  logic [AW-1:0]        cand;
  logic [AW-1:0]        scan_idx;
  logic                 green_done;

  // Pending requests from any road other than the one holding the phase.
  always_comb begin
    act_onehot           = '0;
    act_onehot[active_q] = 1'b1;
    others               = |(req_q & ~act_onehot);
  end

  // Round-robin pick: nearest pending road after the active one, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    scan_idx = active_q;
    cand     = active_q;
    for (int k = N_ROADS - 1; k >= 1; k--) begin
      cand = wrap_add(active_q, k);
      if (req_q[cand]) scan_idx = cand;
    end
  end

  // Phase sequencing, request latching and phase timer.
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    req_d    = req_q | car;
    green_done = others &&
                 (((cnt_q >= GMIN_LAST) && !car[active_q]) || (cnt_q >= GMAX_LAST));
    case (phase_q)
      PH_GREEN: begin
        // The road that owns the green never keeps a request of its own.
        req_d[active_q] = 1'b0;
        if (green_done) begin
          phase_d = PH_YELLOW;
          next_d  = scan_idx;
          cnt_d   = '0;
        end else if (cnt_q < GMAX_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (cnt_q == YEL_LAST) begin
          cnt_d = '0;
          if (ALLRED_T == 0) begin
            phase_d       = PH_GREEN;
            active_d      = next_q;
            req_d[next_q] = 1'b0;
          end else begin
            phase_d = PH_ALLRED;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_ALLRED: begin
        if (cnt_q == AR_LAST) begin
          cnt_d         = '0;
          phase_d       = PH_GREEN;
          active_d      = next_q;
          req_d[next_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = PH_GREEN;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp decode from the next state so the lamp register lines up with the FSM.
  always_comb begin
    light_d = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      light_d[3*i +: 3] = 3'b001;
      if ((phase_d != PH_ALLRED) && (active_d == AW'(i))) begin
        light_d[3*i +: 3] = (phase_d == PH_GREEN) ? 3'b100 : 3'b010;
      end
    end
  end

  // State, request and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_GREEN;
      active_q <= HOME_IDX;
      next_q   <= HOME_IDX;
      cnt_q    <= '0;
      req_q    <= '0;
      light_q  <= RESET_LIGHT;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      light_q  <= light_d;
    end
  end

  assign light       = light_q;
  assign active_road = active_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_multiway_traffic_ctrl.sv
// Bench for multiway_traffic_ctrl: two instances (with and without the all-red
// phase) share the same car stimulus and are compared every cycle against a
// behavioural model, with a few directed scenarios pinned by literal values.
module tb_multiway_traffic_ctrl;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YT   = 2;
  localparam logic [11:0] RST_LIGHT = 12'b001_001_001_100;

  // ---------------- clock / reset / DUT ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  car   = 4'b0000;
  logic [11:0] light_a, light_b;
  logic [1:0]  act_a, act_b;
  logic [1:0]  ph_a, ph_b;

  always #5 clk = ~clk;

  multiway_traffic_ctrl #(
    .N_ROADS(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(1), .HOME(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .car(car),
    .light(light_a), .active_road(act_a), .phase(ph_a)
  );

  multiway_traffic_ctrl #(
    .N_ROADS(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(0), .HOME(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .car(car),
    .light(light_b), .active_road(act_b), .phase(ph_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: phase (0 green, 1 yellow, 2 all red), road holding the phase,
  // road chosen to go next, cycles spent in the current phase, pending requests.
  int         m_phase [2];
  int         m_active[2];
  int         m_next  [2];
  int         m_age   [2];
  logic [3:0] m_req   [2];
  int         p_allred[2] = '{1, 0};

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_phase[u] = 0; m_active[u] = 0; m_next[u] = 0; m_age[u] = 0; m_req[u] = 4'b0000;
    end
  endtask

  task automatic model_step(input int u, input logic [3:0] c);
    logic [3:0] r;
    logic [3:0] nr;
    int a;
    bit waiting;
    r  = m_req[u];
    a  = m_active[u];
    nr = r | c;
    waiting = 1'b0;
    for (int i = 0; i < N; i++) if (i != a && r[i]) waiting = 1'b1;
    if (m_phase[u] == 0) begin
      nr[a] = 1'b0;
      if (waiting && ((m_age[u] >= GMIN - 1 && !c[a]) || m_age[u] >= GMAX - 1)) begin
        for (int k = 1; k < N; k++) begin
          if (r[(a + k) % N]) begin
            m_next[u] = (a + k) % N;
            break;
          end
        end
        m_phase[u] = 1;
        m_age[u]   = 0;
      end else begin
        m_age[u]++;
      end
    end else if (m_phase[u] == 1) begin
      if (m_age[u] == YT - 1) begin
        m_age[u] = 0;
        if (p_allred[u] == 0) begin
          m_phase[u]  = 0;
          m_active[u] = m_next[u];
          nr[m_next[u]] = 1'b0;
        end else begin
          m_phase[u] = 2;
        end
      end else begin
        m_age[u]++;
      end
    end else begin
      if (m_age[u] == p_allred[u] - 1) begin
        m_age[u]    = 0;
        m_phase[u]  = 0;
        m_active[u] = m_next[u];
        nr[m_next[u]] = 1'b0;
      end else begin
        m_age[u]++;
      end
    end
    m_req[u] = nr;
  endtask

  function automatic logic [11:0] exp_light(input int u);
    logic [11:0] l;
    for (int i = 0; i < N; i++) begin
      if (m_phase[u] == 2 || i != m_active[u]) l[3*i +: 3] = 3'b001;
      else if (m_phase[u] == 0)                l[3*i +: 3] = 3'b100;
      else                                     l[3*i +: 3] = 3'b010;
    end
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, car);
      model_step(1, car);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit b_saw_allred = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("light_a", light_a, exp_light(0));
      check("active_a", act_a, m_active[0]);
      check("phase_a", ph_a, m_phase[0]);
      check("light_b", light_b, exp_light(1));
      check("active_b", act_b, m_active[1]);
      check("phase_b", ph_b, m_phase[1]);
      if (ph_b == 2'd2) b_saw_allred = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  int rec_ph_a[16], rec_act_a[16], rec_ph_b[16], rec_act_b[16];

  // Reset asserted between edges; outputs must return to the reset state at once.
  task automatic reset_and_check(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    car   = 4'b0000;
    #1;
    check({tag, "_rst_light_a"}, light_a, RST_LIGHT);
    check({tag, "_rst_act_a"}, act_a, 0);
    check({tag, "_rst_ph_a"}, ph_a, 0);
    check({tag, "_rst_light_b"}, light_b, RST_LIGHT);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Records outputs for cycle k, then applies car for that cycle.
  task automatic run_recorded(input int ncyc, input logic [3:0] first_car, input logic [3:0] rest_car);
    for (int k = 0; k < ncyc; k++) begin
      rec_ph_a[k] = ph_a; rec_act_a[k] = act_a;
      rec_ph_b[k] = ph_b; rec_act_b[k] = act_b;
      car = (k == 0) ? first_car : rest_car;
      @(negedge clk);
    end
    car = 4'b0000;
  endtask

  // ---------------- main sequence ----------------
  int ord_a[$], ord_b[$];
  int prev_a, prev_b;
  int idle_changes;
  logic [3:0] hold;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single pulse on road 2 right after reset.
    run_recorded(10, 4'b0100, 4'b0000);
    check("t3_a_green_c3", rec_ph_a[3], 0);
    check("t3_a_yellow_c4", rec_ph_a[4], 1);
    check("t3_a_yellow_c5", rec_ph_a[5], 1);
    check("t3_a_allred_c6", rec_ph_a[6], 2);
    check("t3_a_green_c7", rec_ph_a[7], 0);
    check("t3_a_road_c7", rec_act_a[7], 2);
    check("t3_b_yellow_c5", rec_ph_b[5], 1);
    check("t3_b_green_c6", rec_ph_b[6], 0);
    check("t3_b_road_c6", rec_act_b[6], 2);

    // Road 2 green: roads 1 and 3 request together -> 3 then 1.
    car = 4'b1010;
    @(negedge clk);
    car = 4'b0000;
    prev_a = act_a; prev_b = act_b;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (act_a != prev_a) ord_a.push_back(act_a);
      if (act_b != prev_b) ord_b.push_back(act_b);
      prev_a = act_a; prev_b = act_b;
    end
    check("t5_a_served", ord_a.size(), 2);
    check("t5_b_served", ord_b.size(), 2);
    if (ord_a.size() >= 2) begin
      check("t5_a_first", ord_a[0], 3);
      check("t5_a_second", ord_a[1], 1);
    end
    if (ord_b.size() >= 2) begin
      check("t5_b_first", ord_b[0], 3);
      check("t5_b_second", ord_b[1], 1);
    end

    // Own car held: green ends only at the maximum.
    reset_and_check("t4");
    run_recorded(12, 4'b0011, 4'b0001);
    check("t4_a_green_c7", rec_ph_a[7], 0);
    check("t4_a_yellow_c8", rec_ph_a[8], 1);
    check("t4_a_road_c8", rec_act_a[8], 0);

    // Idle after reset: nothing moves.
    reset_and_check("t2");
    idle_changes = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (light_a !== RST_LIGHT || ph_a !== 2'd0) idle_changes++;
    end
    check("t2_idle_changes", idle_changes, 0);

    // Randomised traffic with occasionally held sensors and one mid-run reset.
    hold = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      if (k % 16 == 0) hold = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      car = hold;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) car[i] = 1'b1;
      @(negedge clk);
      if (k == 1500) reset_and_check("mid");
    end
    car = 4'b0000;
    @(negedge clk);

    check("b_no_allred", b_saw_allred, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
